interval_timer: RTL
===================

Name: interval_timer

Overview:
- Consumer/reader side of the interval parameter store.
- Given a start request and an interval select from the traffic-light FSM, it drives `interval_address` to the parameter store and captures the returned 4-bit `output_value`.
- It then counts that many 1 Hz enable ticks and raises a one-cycle `expired` pulse back to the FSM.
- It sits between the parameter store, the 1 Hz divider and the controller FSM.

Parameters:
- VALUE_W, 4, width of interval values and of the down-counter (matches parameter store output).
- ADDR_W, 2, width of the interval address.

Ports:
- clk  input  1  system clock.
- sys_reset  input  1  asynchronous, active-high reset.
- start_timer  input  1  one-cycle request to (re)start timing the selected interval.
- interval_sel  input  ADDR_W  interval to time: 00 base, 01 extended, 10 yellow, 11 forwarded unchanged.
- interval_address  output  ADDR_W  registered read address to the parameter store.
- output_value  input  VALUE_W  combinational read data from the parameter store for `interval_address`.
- one_hz_enable  input  1  single-cycle 1 Hz tick from the divider.
- expired  output  1  one-cycle pulse when the interval has elapsed.
- busy  output  1  high in FETCH and COUNT states.
- remaining  output  VALUE_W  current down-counter value (for display/debug).

Behaviour:
- **Reset (async, sys_reset=1):**
  - state=IDLE.
  - interval_address=0, remaining=0, expired=0, busy=0.
  - Reset mid-count aborts with no expired pulse.
- **States:** IDLE, FETCH, COUNT, EXPIRE. All outputs are registered or Moore-decoded from state.
- **IDLE:** on start_timer → interval_address<=interval_sel; go to FETCH.
- **FETCH (exactly 1 cycle):**
  - remaining<=output_value.
  - Next state is EXPIRE if output_value==0, else COUNT.
  - one_hz_enable is ignored in FETCH.
- **COUNT:** on one_hz_enable:
  - remaining==1 → remaining<=0, go to EXPIRE.
  - Otherwise remaining<=remaining-1.
  - Without a tick, remaining holds.
- **EXPIRE (1 cycle):**
  - expired=1.
  - Next state is IDLE, or FETCH if start_timer is high (interval_address reloaded).
- **start_timer priority:** start_timer in any state is a retrigger. interval_address<=interval_sel, next state FETCH, and it overrides a coincident tick. Retrigger from COUNT produces no expired pulse.
- **Latency:**
  - start at cycle N; FETCH at N+1; COUNT at N+2.
  - expired is asserted in the cycle after the Vth tick seen in COUNT.
  - A zero value gives expired at N+2.
- **Snapshot semantics:** the value is captured once in FETCH. Reprogramming of the parameter store while counting does not affect the running count; the new value applies at the next start.
- **Arithmetic:** unsigned VALUE_W. remaining never wraps below 0, and the decrement is never applied at 0.
- **Address hold:** interval_address holds its last value between starts, including through expiry.

Decomposition:
- Shared package: state encoding localparams (IDLE, FETCH, COUNT, EXPIRE) and interval address constants (ADDR_BASE=2'b00, ADDR_EXT=2'b01, ADDR_YEL=2'b10).
- The parameter store and controller FSM use the same package.
- Single module; no sub-module. The down-counter is inline.

Test Plan:
Bench models the parameter store as a combinational lookup: 00→6, 01→3, 10→2, 11→0. Ticks occur every 5 clocks.
1. Reset asserted mid-COUNT, asynchronously between clock edges → outputs go to 0 immediately, no expired pulse; after release, state is IDLE.
2. start_timer with sel=00 →
   - interval_address=00 at N+1;
   - remaining=6 at N+2;
   - exactly one expired pulse, one cycle after the 6th tick in COUNT;
   - busy low afterwards.
3. sel=11 (value 0) → expired at N+2 with zero ticks required; busy high for one cycle (FETCH).
4. start sel=01 (value 3); after 1 tick, retrigger with sel=10 → no expired for the first interval; remaining=2; expired after 2 more ticks.
5. Snapshot semantics:
   - start sel=01 (value 3); after 1 tick, the model changes address 01 to 10 (4'b1010) → the current run still expires after 3 total ticks;
   - the next start with sel=01 loads remaining=10 and expires after 10 ticks.
6. start_timer during EXPIRE and a tick coinciding with start → expired still pulses once, FETCH follows with the new address, and the coincident tick is not counted.

Source files
------------

// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg: state encoding and interval address constants shared by the timer, parameter store and controller FSM.
package interval_timer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t FETCH  = 2'd1;
  localparam state_t COUNT  = 2'd2;
  localparam state_t EXPIRE = 2'd3;
  localparam logic [1:0] ADDR_BASE = 2'b00;
  localparam logic [1:0] ADDR_EXT  = 2'b01;
  localparam logic [1:0] ADDR_YEL  = 2'b10;
endpackage

// File: rtl/interval_timer.sv
// interval_timer: fetches an interval from the parameter store, counts that many 1 Hz ticks, then pulses expired.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int VALUE_W = 4,
  parameter int ADDR_W  = 2
) (
  input  logic               clk,
  input  logic               sys_reset,
  input  logic               start_timer,
  input  logic [ADDR_W-1:0]  interval_sel,
  output logic [ADDR_W-1:0]  interval_address,
  input  logic [VALUE_W-1:0] output_value,
  input  logic               one_hz_enable,
  output logic               expired,
  output logic               busy,
  output logic [VALUE_W-1:0] remaining
);
  state_t r_state;
  state_t w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [VALUE_W-1:0] r_rem;
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // start_timer retriggers from any state and beats a coincident tick
  always_comb begin
    w_next = start_timer ? FETCH :
             (r_state == FETCH) ? ((output_value == '0) ? EXPIRE : COUNT) :
             (r_state == COUNT) ? ((one_hz_enable && r_rem == VALUE_W'(1)) ? EXPIRE : COUNT) :
             IDLE;
  end
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else begin
      if (start_timer) r_addr <= interval_sel;
      if (r_state == FETCH) r_rem <= output_value;
      else if (r_state == COUNT && one_hz_enable && !start_timer && r_rem != '0) r_rem <= r_rem - 1'b1;
    end
  end
  always_comb begin
    expired = (r_state == EXPIRE);
    busy    = (r_state == FETCH) || (r_state == COUNT);
  end
  assign interval_address = r_addr;
  assign remaining        = r_rem;
endmodule
